// File: rtl/ascon_patch_sched_pkg.sv
// rtl/ascon_patch_sched_pkg.sv - shared encodings, state and request types for the ASCON patch scheduler
package ascon_patch_sched_pkg;

  localparam int PATCH_SEL_BITS = 3;

  // Same values the core uses for ctrl_transfer_insn_in_id
  typedef enum logic [1:0] {
    BRANCH_NONE = 2'b00,
    BRANCH_JAL  = 2'b01,
    BRANCH_JALR = 2'b10,
    BRANCH_COND = 2'b11
  } branch_e;

  typedef enum logic [PATCH_SEL_BITS-1:0] {
    PATCH_NULL = 3'd0,
    PATCH_ID   = 3'd1,
    PATCH_IF   = 3'd2,
    PATCH_EX   = 3'd3,
    PATCH_TRAP = 3'd4
  } patch_sel_e;

  typedef struct packed {
    patch_sel_e sel;
    logic       prev_addr;
    logic       destplus8;
  } patch_req_t;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_WAIT_DISC,
    ST_JUMP_IN_ID_WAIT,
    ST_BRANCH_IN_ID
  } sched_state_e;

  function automatic patch_req_t f_mk_req(input patch_sel_e sel, input logic prev_addr,
                                          input logic destplus8);
    patch_req_t r;
    r.sel       = sel;
    r.prev_addr = prev_addr;
    r.destplus8 = destplus8;
    return r;
  endfunction

endpackage

// File: rtl/ascon_patch_sched_if.sv
// rtl/ascon_patch_sched_if.sv - patch request handshake between scheduler and ASCON datapath
interface ascon_patch_sched_if #(
  parameter int PATCH_SEL_W = 3
);
  logic                   patch_valid_o;
  logic                   patch_ready_i;
  logic [PATCH_SEL_W-1:0] patch_sel_o;
  logic                   patch_prev_addr_en_o;

  modport master (
    output patch_valid_o,
    output patch_sel_o,
    output patch_prev_addr_en_o,
    input  patch_ready_i
  );

  modport slave (
    input  patch_valid_o,
    input  patch_sel_o,
    input  patch_prev_addr_en_o,
    output patch_ready_i
  );
endinterface

// File: rtl/ascon_patch_sched_fifo.sv
// rtl/ascon_patch_sched_fifo.sv - sync FIFO of patch requests; drops pushes while full and flags it
module ascon_patch_sched_fifo
  import ascon_patch_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  patch_req_t       i_req,
  input  logic             i_pop,
  output patch_req_t       o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  patch_req_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_pop;
  logic             w_push;

  // Explicit wrap keeps non-power-of-2 depths correct
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (i_push && !w_push)     r_overflow <= 1'b1;
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ascon_patch_sched.sv
// rtl/ascon_patch_sched.sv - detects control transfers and traps, queues them and issues patches to ASCON
module ascon_patch_sched
  import ascon_patch_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int CS_DELAY    = 1,
  parameter int PATCH_SEL_W = 3
) (
  input  logic                              clk_core_slow_i,
  input  logic                              rst_i,
  input  logic [1:0]                        ctrl_transfer_insn_in_id_i,
  input  logic                              branch_in_ex_i,
  input  logic                              branch_decision_i,
  input  logic                              pc_set_i,
  input  logic                              redirection_in_id_i,
  input  logic                              trap_taken_i,
  ascon_patch_sched_if.master               patch_if,
  output logic                              sel_state_init_o,
  output logic                              clk_ascon_fast_cnt_init_o,
  output logic                              clk_ascon_fast_cnt_en_o,
  output logic                              sel_addr_redirected_o,
  output logic                              apply_patch_cs_o,
  output logic                              en_apply_patch_cs_destplus8_o,
  output logic                              halt_id_o,
  output logic                              fifo_overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_cnt_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  sched_state_e     r_state;
  sched_state_e     w_next;
  sched_state_e     w_dec_next;
  branch_e          w_ctrl;
  logic             w_jump;
  logic             w_dec_detect;
  logic             w_detect;
  logic             w_redir;
  patch_req_t       w_jump_req;
  patch_req_t       w_req;
  patch_req_t       w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_valid;
  logic             w_pop;

  assign w_ctrl = branch_e'(ctrl_transfer_insn_in_id_i);
  assign w_jump = (w_ctrl == BRANCH_JAL) || (w_ctrl == BRANCH_JALR);

  always_comb begin
    w_jump_req = f_mk_req(PATCH_IF, 1'b0, 1'b0);
    if (w_ctrl == BRANCH_JAL) w_jump_req.sel = PATCH_ID;
    w_jump_req.prev_addr = (w_ctrl == BRANCH_JALR) && redirection_in_id_i;
  end

  // Decode of the ID-stage instruction, shared by WAIT_DISC and a not-taken branch
  always_comb begin
    w_dec_next   = ST_WAIT_DISC;
    w_dec_detect = 1'b0;
    case (w_ctrl)
      BRANCH_COND: w_dec_next = ST_BRANCH_IN_ID;
      BRANCH_JAL, BRANCH_JALR: begin
        if (pc_set_i) w_dec_detect = 1'b1;
        else          w_dec_next   = ST_JUMP_IN_ID_WAIT;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_detect = 1'b0;
    w_req    = w_jump_req;
    case (r_state)
      ST_RESET: if (pc_set_i) w_next = ST_WAIT_DISC;
      ST_WAIT_DISC: begin
        w_next   = w_dec_next;
        w_detect = w_dec_detect;
      end
      ST_JUMP_IN_ID_WAIT: if (pc_set_i && w_jump) begin
        w_detect = 1'b1;
        w_next   = ST_WAIT_DISC;
      end
      ST_BRANCH_IN_ID: if (branch_in_ex_i) begin
        if (branch_decision_i) begin
          w_detect = 1'b1;
          w_req    = f_mk_req(PATCH_EX, 1'b0, 1'b1);
          w_next   = ST_WAIT_DISC;
        end else begin
          w_next   = w_dec_next;
          w_detect = w_dec_detect;
        end
      end
      default: w_next = ST_RESET;
    endcase
    w_redir = w_detect && w_req.prev_addr;
    // A trap overrides whatever else was detected this cycle
    if ((r_state != ST_RESET) && trap_taken_i) begin
      w_detect = 1'b1;
      w_req    = f_mk_req(PATCH_TRAP, 1'b0, 1'b0);
      w_next   = ST_WAIT_DISC;
      w_redir  = 1'b0;
    end
  end

  always_ff @(posedge clk_core_slow_i) begin
    if (rst_i) r_state <= ST_RESET;
    else       r_state <= w_next;
  end

  ascon_patch_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_core_slow_i),
    .rst        (rst_i),
    .i_push     (w_detect),
    .i_req      (w_req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (fifo_overflow_o)
  );

  assign w_valid = !w_empty;
  assign w_pop   = w_valid && patch_if.patch_ready_i;

  assign patch_if.patch_valid_o        = w_valid;
  assign patch_if.patch_sel_o          = w_valid ? PATCH_SEL_W'(w_head.sel) : PATCH_SEL_W'(PATCH_NULL);
  assign patch_if.patch_prev_addr_en_o = w_valid && w_head.prev_addr;

  assign sel_state_init_o          = (r_state == ST_RESET);
  assign clk_ascon_fast_cnt_init_o = (r_state == ST_RESET);
  assign clk_ascon_fast_cnt_en_o   = (r_state != ST_RESET);
  assign sel_addr_redirected_o     = w_redir;
  assign halt_id_o                 = w_full || (w_count == CNT_W'(FIFO_DEPTH - 1));
  assign pending_cnt_o             = w_count;

  generate
    if (CS_DELAY == 0) begin : g_cs_comb
      assign apply_patch_cs_o              = w_pop;
      assign en_apply_patch_cs_destplus8_o = w_pop && w_head.destplus8;
    end else begin : g_cs_pipe
      logic [CS_DELAY-1:0] r_apply;
      logic [CS_DELAY-1:0] r_dp8;
      always_ff @(posedge clk_core_slow_i) begin
        if (rst_i) begin
          r_apply <= '0;
          r_dp8   <= '0;
        end else begin
          r_apply[0] <= w_pop;
          r_dp8[0]   <= w_pop && w_head.destplus8;
          for (int i = 1; i < CS_DELAY; i++) begin
            r_apply[i] <= r_apply[i-1];
            r_dp8[i]   <= r_dp8[i-1];
          end
        end
      end
      assign apply_patch_cs_o              = r_apply[CS_DELAY-1];
      assign en_apply_patch_cs_destplus8_o = r_dp8[CS_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_ascon_patch_sched.sv
// tb/tb_ascon_patch_sched.sv - directed self-checking bench for ascon_patch_sched
module tb_ascon_patch_sched;

  logic       clk;
  logic       rst;
  logic [1:0] ctrl;
  logic       bin_ex;
  logic       bdec;
  logic       pc_set;
  logic       redir;
  logic       trap;
  logic       sel_init;
  logic       cnt_init;
  logic       cnt_en;
  logic       redirected;
  logic       apply;
  logic       dp8;
  logic       halt;
  logic       ovf;
  logic [2:0] cnt;

  int n_checks = 0;
  int n_errs   = 0;

  logic [2:0] exp_sel  [4] = '{3'd2, 3'd2, 3'd1, 3'd2};
  logic       exp_prev [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  ascon_patch_sched_if #(.PATCH_SEL_W(3)) pif ();

  ascon_patch_sched #(
    .FIFO_DEPTH  (4),
    .CS_DELAY    (1),
    .PATCH_SEL_W (3)
  ) dut (
    .clk_core_slow_i               (clk),
    .rst_i                         (rst),
    .ctrl_transfer_insn_in_id_i    (ctrl),
    .branch_in_ex_i                (bin_ex),
    .branch_decision_i             (bdec),
    .pc_set_i                      (pc_set),
    .redirection_in_id_i           (redir),
    .trap_taken_i                  (trap),
    .patch_if                      (pif),
    .sel_state_init_o              (sel_init),
    .clk_ascon_fast_cnt_init_o     (cnt_init),
    .clk_ascon_fast_cnt_en_o       (cnt_en),
    .sel_addr_redirected_o         (redirected),
    .apply_patch_cs_o              (apply),
    .en_apply_patch_cs_destplus8_o (dp8),
    .halt_id_o                     (halt),
    .fifo_overflow_o               (ovf),
    .pending_cnt_o                 (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ctrl   = 2'b00;
    bin_ex = 1'b0;
    bdec   = 1'b0;
    pc_set = 1'b0;
    redir  = 1'b0;
    trap   = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    pif.patch_ready_i = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_sel_init", sel_init, 1);
    chk("rst_cnt_init", cnt_init, 1);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_valid", pif.patch_valid_o, 0);
    chk("rst_sel", pif.patch_sel_o, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_halt", halt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_apply", apply, 0);

    // leave RESET, then JAL with pc_set
    rst = 1'b0;
    pc_set = 1'b1;
    tick();
    chk("run_cnt_init", cnt_init, 0);
    chk("run_cnt_en", cnt_en, 1);
    chk("run_sel_init", sel_init, 0);
    ctrl = 2'b01;
    pif.patch_ready_i = 1'b1;
    #1;
    chk("jal_no_bypass", pif.patch_valid_o, 0);
    chk("jal_redir0", redirected, 0);
    tick();
    idle();
    #1;
    chk("jal_valid", pif.patch_valid_o, 1);
    chk("jal_sel", pif.patch_sel_o, 1);
    chk("jal_prev", pif.patch_prev_addr_en_o, 0);
    chk("jal_cnt", cnt, 1);
    chk("jal_apply_early", apply, 0);
    tick();
    chk("jal_apply", apply, 1);
    chk("jal_dp8", dp8, 0);
    chk("jal_drained", cnt, 0);
    chk("jal_sel_null", pif.patch_sel_o, 0);
    tick();
    chk("jal_apply_pulse", apply, 0);

    // redirection JALR
    pif.patch_ready_i = 1'b0;
    ctrl = 2'b10;
    pc_set = 1'b1;
    redir = 1'b1;
    #1;
    chk("redir_comb", redirected, 1);
    tick();
    idle();
    #1;
    chk("redir_sel", pif.patch_sel_o, 2);
    chk("redir_prev", pif.patch_prev_addr_en_o, 1);
    pif.patch_ready_i = 1'b1;
    tick();
    pif.patch_ready_i = 1'b0;
    #1;
    chk("redir_apply", apply, 1);
    chk("redir_cnt", cnt, 0);

    // taken branch held with ready low
    ctrl = 2'b11;
    tick();
    ctrl = 2'b00;
    bin_ex = 1'b1;
    bdec = 1'b1;
    #1;
    chk("br_redir0", redirected, 0);
    tick();
    idle();
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("br_hold_sel", pif.patch_sel_o, 3);
      chk("br_hold_valid", pif.patch_valid_o, 1);
      chk("br_hold_apply", apply, 0);
      tick();
    end
    pif.patch_ready_i = 1'b1;
    tick();
    pif.patch_ready_i = 1'b0;
    #1;
    chk("br_dp8", dp8, 1);
    chk("br_apply", apply, 1);
    tick();
    chk("br_dp8_pulse", dp8, 0);

    // fill, full push+pop, then overflow
    ctrl = 2'b01; pc_set = 1'b1;
    tick();
    chk("fill1_cnt", cnt, 1);
    ctrl = 2'b10;
    tick();
    chk("fill2_cnt", cnt, 2);
    chk("fill2_halt", halt, 0);
    redir = 1'b1;
    tick();
    chk("fill3_cnt", cnt, 3);
    chk("fill3_halt", halt, 1);
    ctrl = 2'b01; redir = 1'b0;
    tick();
    chk("fill4_cnt", cnt, 4);
    chk("fill4_ovf", ovf, 0);
    ctrl = 2'b10; redir = 1'b1;
    pif.patch_ready_i = 1'b1;
    tick();
    chk("fullpp_cnt", cnt, 4);
    chk("fullpp_ovf", ovf, 0);
    chk("fullpp_apply", apply, 1);
    ctrl = 2'b01; redir = 1'b0;
    pif.patch_ready_i = 1'b0;
    tick();
    chk("ovf_cnt", cnt, 4);
    chk("ovf_flag", ovf, 1);
    idle();
    pif.patch_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_sel", pif.patch_sel_o, exp_sel[i]);
      chk("drain_prev", pif.patch_prev_addr_en_o, exp_prev[i]);
      tick();
    end
    pif.patch_ready_i = 1'b0;
    #1;
    chk("drain_cnt", cnt, 0);
    chk("drain_ovf_sticky", ovf, 1);
    chk("drain_halt", halt, 0);

    // trap with taken branch
    ctrl = 2'b11;
    tick();
    ctrl = 2'b00; bin_ex = 1'b1; bdec = 1'b1; trap = 1'b1;
    #1;
    chk("trap_redir0", redirected, 0);
    tick();
    idle();
    #1;
    chk("trap_cnt", cnt, 1);
    chk("trap_sel", pif.patch_sel_o, 4);
    chk("trap_dp8_field", pif.patch_prev_addr_en_o, 0);
    // a JAL with pc_set is taken at once only if the FSM went to WAIT_DISC
    ctrl = 2'b01; pc_set = 1'b1;
    pif.patch_ready_i = 1'b1;
    tick();
    idle();
    pif.patch_ready_i = 1'b0;
    #1;
    chk("trap_wait_cnt", cnt, 1);
    chk("trap_wait_sel", pif.patch_sel_o, 1);
    chk("trap_apply", apply, 1);
    chk("trap_no_dp8", dp8, 0);

    // trap with redirection JALR
    ctrl = 2'b10; pc_set = 1'b1; redir = 1'b1; trap = 1'b1;
    #1;
    chk("trapj_redir0", redirected, 0);
    tick();
    idle();
    #1;
    chk("trapj_cnt", cnt, 2);
    pif.patch_ready_i = 1'b1;
    tick();
    chk("trapj_sel", pif.patch_sel_o, 4);
    chk("trapj_prev", pif.patch_prev_addr_en_o, 0);
    tick();
    pif.patch_ready_i = 1'b0;
    #1;
    chk("trapj_cnt0", cnt, 0);

    // reset with entries pending and a CS pulse in flight
    ctrl = 2'b01; pc_set = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    pif.patch_ready_i = 1'b1;
    tick();
    chk("pre_rst_cnt", cnt, 3);
    chk("pre_rst_apply", apply, 1);
    chk("pre_rst_ovf", ovf, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_apply", apply, 0);
    chk("mid_rst_dp8", dp8, 0);
    chk("mid_rst_sel_init", sel_init, 1);
    chk("mid_rst_cnt_en", cnt_en, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_valid", pif.patch_valid_o, 0);
    chk("mid_rst_halt", halt, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
